alu_exec: RTL

- Execute-stage ALU that consumes the 4-bit ALUop code produced by the ALU control decoder and computes the result for the datapath.
- Single-cycle ops finish one cycle after start. Shifts run iteratively, one bit per clock, to keep the barrel shifter out of the critical path.
- Uses a start/busy/done handshake so the multicycle controller can stall on shifts.

---
 rtl/alu_exec.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a start/busy/done handshake.
// Single-cycle ops finish one edge after the accepting edge.
// Shifts run one bit per clock so that no barrel shifter is built.
// Optional feature macro: ALU_SRA_EN adds ALUop 1000 (arithmetic right shift).
// Without the macro, 1000 is reported as illegal and no sign-fill logic exists.
module alu_exec #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_EQ0 = 4'b1110;
    localparam logic [3:0] OP_SLT = 4'b1111;
`ifdef ALU_SRA_EN
    localparam logic [3:0] OP_SRA = 4'b1000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT
    } state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [SHW-1:0]   count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             illegal_reg;

    // Combinational decode of the captured op
    logic [WIDTH-1:0] single_next;
    logic             op_illegal;
    logic             op_shift;
    logic [SHW-1:0]   amount;

    // One-bit shift step candidates
    logic [WIDTH-1:0] left_step;
    logic [WIDTH-1:0] right_step;
    logic [WIDTH-1:0] shift_next;
    logic             fill_bit;

    assign amount = b_reg[SHW-1:0];

    // Result of every single-cycle op; shift ops pass a through so amount 0 yields a
    always_comb begin
        single_next = '0;
        op_illegal  = 1'b0;
        op_shift    = 1'b0;
        case (op_reg)
            OP_ADD: single_next = a_reg + b_reg;
            OP_OR:  single_next = a_reg | b_reg;
            OP_XOR: single_next = a_reg ^ b_reg;
            OP_AND: single_next = a_reg & b_reg;
            OP_NOR: single_next = ~(a_reg | b_reg);
            OP_SUB: single_next = a_reg - b_reg;
            OP_EQ0: single_next = {{(WIDTH-1){1'b0}}, (a_reg == '0)};
            OP_SLT: single_next = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            OP_SLL, OP_SRL: begin
                op_shift    = 1'b1;
                single_next = a_reg;
            end
`ifdef ALU_SRA_EN
            OP_SRA: begin
                op_shift    = 1'b1;
                single_next = a_reg;
            end
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    // The bit shifted into the MSB on a right step: sign for sra, zero for srl
`ifdef ALU_SRA_EN
    assign fill_bit = (op_reg == OP_SRA) & shift_reg[WIDTH-1];
`else
    assign fill_bit = 1'b0;
`endif

    // Per-bit wiring of the single-position left and right shift
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_left_lsb
                assign left_step[gi] = 1'b0;
            end else begin : g_left_mid
                assign left_step[gi] = shift_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_right_msb
                assign right_step[gi] = fill_bit;
            end else begin : g_right_mid
                assign right_step[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign shift_next = (op_reg == OP_SLL) ? left_step : right_step;

    // Control FSM and registered outputs; reset discards any in-flight op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            shift_reg   <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
            illegal_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg      <= ALUop;
                        a_reg       <= a;
                        b_reg       <= b;
                        illegal_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_shift && (amount != '0)) begin
                        shift_reg <= a_reg;
                        count_reg <= amount;
                        state_reg <= ST_SHIFT;
                    end else begin
                        result_reg  <= single_next;
                        zero_reg    <= (single_next == '0);
                        illegal_reg <= op_illegal;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == SHW'(1)) begin
                        result_reg <= shift_next;
                        zero_reg   <= (shift_next == '0);
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign zero    = zero_reg;
    assign illegal = illegal_reg;

endmodule
